seq_divider: RTL
================

// Module: seq_divider
// PURPOSE
//  Multi-cycle unsigned restoring divider; inverse of the ALU's combinational 4x4 multiplier.
//  Takes an 8-bit dividend (multiplier product width) and a 4-bit divisor.
//  Returns quotient and remainder after a start/done handshake, one quotient bit per clock.
//  Sits beside the ALU as a sequential coprocessor; the ALU opcode space is unchanged.
// PARAMETERS
//  DW  8  dividend and quotient width
//  VW  4  divisor and remainder width (VW <= DW)
// PORTS
//  clk           in   1   single clock; all state updates on rising edge
//  reset_n       in   1   synchronous, active-low reset
//  start         in   1   request; accepted only on an edge where ready=1
//  dividend      in   DW  unsigned; sampled on accept edge only
//  divisor       in   VW  unsigned; sampled on accept edge only
//  ready         out  1   1 iff state==IDLE
//  busy          out  1   1 iff state==RUN
//  done          out  1   1-cycle pulse, high iff state==DONE
//  quotient      out  DW  registered result
//  remainder     out  VW  registered result
//  div_by_zero   out  1   registered; 1 when the accepted divisor was 0
// BEHAVIOUR
//  Reset (reset_n=0 at an edge): state=IDLE, counter=0, quotient=0, remainder=0, div_by_zero=0.
//    Resulting outputs: ready=1, busy=0, done=0. Reset wins over any operation; aborted op yields no done.
//  FSM IDLE -> RUN on start=1. RUN -> DONE after the DW-th iteration. DONE -> IDLE unconditionally.
//  Accept edge: latch dividend into shift reg Q, divisor into D.
//    Partial remainder R (VW+1 bits) := 0; counter := 0; div_by_zero <= (divisor==0).
//  RUN, each edge: T = {R[VW-1:0], Q[DW-1]}; Q = {Q[DW-2:0], 1'b0}.
//    If T >= {1'b0, D}: R = T - D, Q[0] = 1. Otherwise R = T, Q[0] = 0.
//    counter increments by 1.
//  On the edge leaving RUN: quotient <= Q; remainder <= R[VW-1:0]. Outputs hold until the next entry to DONE.
//  Latency: done is high in the cycle after the DW-th edge following the accept edge (DW=8 -> 8 edges).
//  Throughput: one op per DW+2 cycles. The next start is accepted in IDLE, the cycle after DONE.
//  start while RUN or DONE: ignored and not queued. Inputs changing during RUN: no effect.
//  Divide by zero: quotient = all ones; remainder = dividend[VW-1:0]; div_by_zero = 1.
//    These values fall out of the algorithm naturally.
//  No overflow possible: the quotient fits DW bits and the remainder is always < divisor.
// CONFIGURATION
//  DIV_ZERO_FAST_EN defined: divisor==0 at accept takes IDLE -> DONE directly.
//    done then asserts after 1 edge, with quotient = all ones, remainder = dividend[VW-1:0], div_by_zero = 1.
//  Undefined: zero divisor runs the full DW iterations; result values are identical.
//  Only latency differs between the two builds. Nonzero divisors behave identically in both.
// STRUCTURE
//  Package div_pkg holds:
//    state encoding localparams S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2;
//    default widths DIV_DW=8 and DIV_VW=4;
//    counter width function clog2(DW+1).
//  Sub-module div_step: purely combinational single restoring iteration.
//    Inputs R, D, next dividend bit. Outputs new R and quotient bit.
//  Top: FSM, counter, shift/result registers and one div_step instance.
// TESTING
//  200/7: 8'hC8 / 4'h7 -> quotient=28, remainder=4, div_by_zero=0; done exactly 8 edges after accept.
//  255/15 then 5/9 back-to-back: start held high -> 17 r 0, then 0 r 5; second accept in IDLE after first DONE.
//  Zero divisor 8'hA5 / 0 -> quotient=8'hFF, remainder=4'h5, div_by_zero=1.
//    Latency 1 with DIV_ZERO_FAST_EN, 8 without.
//  Reset mid-op: 100/3 accepted, reset_n=0 at RUN edge 4 -> next cycle ready=1, done=0, quotient=0, remainder=0.
//    No done pulse follows.
//  Busy-ignore: start pulsed during RUN with 9/2 -> first op's result unchanged; no extra done.
//  Exhaustive: all 256x15 nonzero pairs -> quotient*divisor + remainder == dividend and remainder < divisor.
//    Cross-check quotient*divisor against the ALU multiplier for dividends < 16.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state
// encoding, default operand widths and a constant-width helper.
// Build option: DIV_ZERO_FAST_EN (see seq_divider.sv).
package div_pkg;

  // FSM state encoding (plain constants so older tools and netlists see fixed codes)
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Default widths: dividend matches the 4x4 multiplier product, divisor one factor
  localparam int DIV_DW = 8;
  localparam int DIV_VW = 4;

  // Ceiling log2 with a floor of 1 bit, used to size the iteration counter
  function automatic int clog2(input int value);
    int width;
    int span;
    width = 0;
    span  = 1;
    while (span < value) begin
      span  = span << 1;
      width = width + 1;
    end
    return (width == 0) ? 1 : width;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift the next dividend
// bit into the partial remainder, trial-subtract the divisor, and keep the
// difference only when it does not go negative.
module div_step
  import div_pkg::*;
#(
  parameter int VW = DIV_VW
) (
  input  logic [VW:0]   r_in,
  input  logic [VW-1:0] d,
  input  logic          bit_in,
  output logic [VW:0]   r_out,
  output logic          q_bit
);

  logic [VW:0] t;
  // The top bit of the incoming remainder is shifted out and never feeds T
  logic        unused_r_msb;

  assign t            = {r_in[VW-1:0], bit_in};
  assign unused_r_msb = r_in[VW];

  // Trial subtraction: quotient bit is 1 when T covers the divisor
  always_comb begin
    q_bit = (t >= {1'b0, d});
    r_out = q_bit ? (t - {1'b0, d}) : t;
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider with a start/done handshake,
// producing one quotient bit per clock. Companion to the ALU's 4x4
// multiplier; the ALU itself is untouched.
// Build option: define DIV_ZERO_FAST_EN to send a zero divisor straight
// from IDLE to DONE (results identical, latency 1 instead of DW).
module seq_divider
  import div_pkg::*;
#(
  parameter int DW = DIV_DW,
  parameter int VW = DIV_VW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          ready,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int CW = clog2(DW + 1);

  logic [1:0]    state_reg;
  logic [1:0]    state_next;
  logic [CW-1:0] cnt_reg;
  logic [DW-1:0] q_reg;
  logic [VW-1:0] d_reg;
  logic [VW:0]   r_reg;
  logic [DW-1:0] quotient_reg;
  logic [VW-1:0] remainder_reg;
  logic          dbz_reg;

  logic [VW:0]   step_r;
  logic          step_q;
  logic [DW-1:0] q_shift;
  logic          last_iter;
  logic          zero_div;

  div_step #(
    .VW(VW)
  ) u_step (
    .r_in  (r_reg),
    .d     (d_reg),
    .bit_in(q_reg[DW-1]),
    .r_out (step_r),
    .q_bit (step_q)
  );

  // Dividend register doubles as the quotient register: MSB out, new bit in
  assign q_shift   = {q_reg[DW-2:0], step_q};
  assign last_iter = (cnt_reg == CW'(DW - 1));
  assign zero_div  = (divisor == '0);

  assign ready       = (state_reg == S_IDLE);
  assign busy        = (state_reg == S_RUN);
  assign done        = (state_reg == S_DONE);
  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;
  assign div_by_zero = dbz_reg;

  // Next-state logic; start is only honoured in IDLE and is never queued
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
`ifdef DIV_ZERO_FAST_EN
          state_next = zero_div ? S_DONE : S_RUN;
`else
          state_next = S_RUN;
`endif
        end
      end
      S_RUN:   if (last_iter) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // State, iteration datapath and result registers; reset aborts any operation
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      q_reg         <= '0;
      d_reg         <= '0;
      r_reg         <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            q_reg   <= dividend;
            d_reg   <= divisor;
            r_reg   <= '0;
            cnt_reg <= '0;
            dbz_reg <= zero_div;
`ifdef DIV_ZERO_FAST_EN
            // Shortcut produces what the full iteration would: all-ones
            // quotient and the low dividend bits as remainder
            if (zero_div) begin
              quotient_reg  <= '1;
              remainder_reg <= dividend[VW-1:0];
            end
`endif
          end
        end
        S_RUN: begin
          q_reg   <= q_shift;
          r_reg   <= step_r;
          cnt_reg <= cnt_reg + CW'(1);
          if (last_iter) begin
            quotient_reg  <= q_shift;
            remainder_reg <= step_r[VW-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
